new_wbck: RTL and testbench

//   Writeback collector; receiving end of the execution-unit fan-out. Merges result

---
 rtl/new_wbck.sv | 136 +++++++++++++
 tb/tb_new_wbck.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/new_wbck.sv
// new_wbck -- writeback collector.
// Merges ALU, LSU and MUL/DIV result streams into a single registered
// regfile write slot using round-robin arbitration (at most one write/cycle).
//
// Ports:
//   clk, rst                       core clock, async active-high reset
//   <src>2wbck_vld/rdy/wdat/rdidx  per-source result handshake (alu, lsu, muldiv)
//   wbck_ena/rdy/wdat/rdidx        regfile write port (ena/wdat/rdidx registered)
//   wbck_busy                      slot occupied or any source valid
//
// State (round-robin pointer r_rr_last):
//   RR_ALU | ALU granted last, LSU has top priority
//   RR_LSU | LSU granted last, MUL/DIV has top priority
//   RR_MD  | MUL/DIV granted last (reset), ALU has top priority
module new_wbck #(
  parameter int XLEN    = 32,
  parameter int RFIDX_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               alu2wbck_vld,
  output logic               alu2wbck_rdy,
  input  logic [XLEN-1:0]    alu2wbck_wdat,
  input  logic [RFIDX_W-1:0] alu2wbck_rdidx,
  input  logic               lsu2wbck_vld,
  output logic               lsu2wbck_rdy,
  input  logic [XLEN-1:0]    lsu2wbck_wdat,
  input  logic [RFIDX_W-1:0] lsu2wbck_rdidx,
  input  logic               muldiv2wbck_vld,
  output logic               muldiv2wbck_rdy,
  input  logic [XLEN-1:0]    muldiv2wbck_wdat,
  input  logic [RFIDX_W-1:0] muldiv2wbck_rdidx,
  output logic               wbck_ena,
  input  logic               wbck_rdy,
  output logic [XLEN-1:0]    wbck_wdat,
  output logic [RFIDX_W-1:0] wbck_rdidx,
  output logic               wbck_busy
);

  typedef enum logic [1:0] {
    RR_ALU = 2'd0,
    RR_LSU = 2'd1,
    RR_MD  = 2'd2
  } rr_e;

  rr_e                r_rr_last;
  logic               r_slot_vld;
  logic [XLEN-1:0]    r_wdat;
  logic [RFIDX_W-1:0] r_rdidx;

  logic [2:0]         w_vld;   // {muldiv, lsu, alu}
  logic [2:0]         w_gnt;
  logic [2:0]         w_rdy;
  logic               w_can_acc;
  logic               w_acc;
  rr_e                w_gnt_src;
  logic [XLEN-1:0]    w_sel_wdat;
  logic [RFIDX_W-1:0] w_sel_rdidx;

  assign w_vld = {muldiv2wbck_vld, lsu2wbck_vld, alu2wbck_vld};

  // Search order starts just after the last grantee.
  always_comb begin
    w_gnt = 3'b000;
    case (r_rr_last)
      RR_ALU: begin
        if      (w_vld[1]) w_gnt = 3'b010;
        else if (w_vld[2]) w_gnt = 3'b100;
        else if (w_vld[0]) w_gnt = 3'b001;
      end
      RR_LSU: begin
        if      (w_vld[2]) w_gnt = 3'b100;
        else if (w_vld[0]) w_gnt = 3'b001;
        else if (w_vld[1]) w_gnt = 3'b010;
      end
      default: begin
        if      (w_vld[0]) w_gnt = 3'b001;
        else if (w_vld[1]) w_gnt = 3'b010;
        else if (w_vld[2]) w_gnt = 3'b100;
      end
    endcase
  end

  // Same-cycle drain and refill: a draining slot can accept a new result.
  assign w_can_acc = ~r_slot_vld | wbck_rdy;
  // rst gates rdy combinationally so no source sees an accept during reset.
  assign w_rdy     = {3{w_can_acc & ~rst}} & w_gnt;
  assign w_acc     = |w_rdy;

  assign alu2wbck_rdy    = w_rdy[0];
  assign lsu2wbck_rdy    = w_rdy[1];
  assign muldiv2wbck_rdy = w_rdy[2];

  always_comb begin
    w_gnt_src   = RR_ALU;
    w_sel_wdat  = alu2wbck_wdat;
    w_sel_rdidx = alu2wbck_rdidx;
    if (w_gnt[1]) begin
      w_gnt_src   = RR_LSU;
      w_sel_wdat  = lsu2wbck_wdat;
      w_sel_rdidx = lsu2wbck_rdidx;
    end else if (w_gnt[2]) begin
      w_gnt_src   = RR_MD;
      w_sel_wdat  = muldiv2wbck_wdat;
      w_sel_rdidx = muldiv2wbck_rdidx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_last  <= RR_MD;
      r_slot_vld <= 1'b0;
      r_wdat     <= '0;
      r_rdidx    <= '0;
    end else if (w_acc) begin
      r_rr_last <= w_gnt_src;
      if (w_sel_rdidx != '0) begin
        r_slot_vld <= 1'b1;
        r_wdat     <= w_sel_wdat;
        r_rdidx    <= w_sel_rdidx;
      end else begin
        // x0 result is consumed but never written; an accept here implies
        // the slot was empty or draining, so it ends up empty.
        r_slot_vld <= 1'b0;
      end
    end else if (wbck_rdy) begin
      r_slot_vld <= 1'b0;
    end
  end

  assign wbck_ena   = r_slot_vld;
  assign wbck_wdat  = r_wdat;
  assign wbck_rdidx = r_rdidx;
  assign wbck_busy  = r_slot_vld | (|w_vld);

endmodule

// File: tb/tb_new_wbck.sv
// Testbench for new_wbck: directed vector table plus hand-written sequences
// for lone transfer, round-robin from reset and asynchronous reset.
module tb_new_wbck;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_vld, lsu_vld, md_vld;
  logic        alu_rdy, lsu_rdy, md_rdy;
  logic [31:0] alu_wdat, lsu_wdat, md_wdat;
  logic [4:0]  alu_idx, lsu_idx, md_idx;
  logic        wbck_ena, wbck_rdy, wbck_busy;
  logic [31:0] wbck_wdat;
  logic [4:0]  wbck_rdidx;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  new_wbck #(.XLEN(32), .RFIDX_W(5)) dut (
    .clk               (clk),
    .rst               (rst),
    .alu2wbck_vld      (alu_vld),
    .alu2wbck_rdy      (alu_rdy),
    .alu2wbck_wdat     (alu_wdat),
    .alu2wbck_rdidx    (alu_idx),
    .lsu2wbck_vld      (lsu_vld),
    .lsu2wbck_rdy      (lsu_rdy),
    .lsu2wbck_wdat     (lsu_wdat),
    .lsu2wbck_rdidx    (lsu_idx),
    .muldiv2wbck_vld   (md_vld),
    .muldiv2wbck_rdy   (md_rdy),
    .muldiv2wbck_wdat  (md_wdat),
    .muldiv2wbck_rdidx (md_idx),
    .wbck_ena          (wbck_ena),
    .wbck_rdy          (wbck_rdy),
    .wbck_wdat         (wbck_wdat),
    .wbck_rdidx        (wbck_rdidx),
    .wbck_busy         (wbck_busy)
  );

  typedef struct packed {
    logic        av, lv, mv;
    logic [4:0]  ai, li, mi;
    logic        wr;
    logic [2:0]  e_rdy;   // {muldiv, lsu, alu}
    logic        e_busy;
    logic        e_ena;
    logic [4:0]  e_idx;
    logic [31:0] e_wdat;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Source data tags the origin in the top nibble: ALU=A, LSU=B, MUL/DIV=C.
  task automatic drive(input logic av, input logic lv, input logic mv,
                       input logic [4:0] ai, input logic [4:0] li, input logic [4:0] mi,
                       input logic wr);
    alu_vld  = av;  alu_idx = ai;  alu_wdat = 32'hA000_0000 | {27'd0, ai};
    lsu_vld  = lv;  lsu_idx = li;  lsu_wdat = 32'hB000_0000 | {27'd0, li};
    md_vld   = mv;  md_idx  = mi;  md_wdat  = 32'hC000_0000 | {27'd0, mi};
    wbck_rdy = wr;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    //              av lv mv  ai     li     mi     wr    rdy     busy  ena   idx    wdat
    vecs[0]  = '{1'b1,1'b1,1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 3'b001, 1'b1, 1'b1, 5'd1,  32'hA000_0001};
    vecs[1]  = '{1'b1,1'b1,1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 3'b010, 1'b1, 1'b1, 5'd2,  32'hB000_0002};
    vecs[2]  = '{1'b1,1'b1,1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 3'b100, 1'b1, 1'b1, 5'd3,  32'hC000_0003};
    vecs[3]  = '{1'b0,1'b1,1'b0, 5'd0, 5'd4, 5'd0, 1'b0, 3'b000, 1'b1, 1'b1, 5'd3,  32'hC000_0003};
    vecs[4]  = '{1'b0,1'b1,1'b0, 5'd0, 5'd4, 5'd0, 1'b0, 3'b000, 1'b1, 1'b1, 5'd3,  32'hC000_0003};
    vecs[5]  = '{1'b0,1'b1,1'b0, 5'd0, 5'd4, 5'd0, 1'b0, 3'b000, 1'b1, 1'b1, 5'd3,  32'hC000_0003};
    vecs[6]  = '{1'b0,1'b1,1'b0, 5'd0, 5'd4, 5'd0, 1'b0, 3'b000, 1'b1, 1'b1, 5'd3,  32'hC000_0003};
    vecs[7]  = '{1'b0,1'b1,1'b0, 5'd0, 5'd4, 5'd0, 1'b1, 3'b010, 1'b1, 1'b1, 5'd4,  32'hB000_0004};
    vecs[8]  = '{1'b0,1'b0,1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 3'b000, 1'b1, 1'b0, 5'd0,  32'h0};
    vecs[9]  = '{1'b1,1'b0,1'b1, 5'd5, 5'd0, 5'd6, 1'b0, 3'b100, 1'b1, 1'b1, 5'd6,  32'hC000_0006};
    vecs[10] = '{1'b1,1'b1,1'b0, 5'd7, 5'd8, 5'd0, 1'b0, 3'b000, 1'b1, 1'b1, 5'd6,  32'hC000_0006};
    vecs[11] = '{1'b1,1'b1,1'b0, 5'd7, 5'd8, 5'd0, 1'b1, 3'b001, 1'b1, 1'b1, 5'd7,  32'hA000_0007};
    vecs[12] = '{1'b0,1'b0,1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 3'b100, 1'b1, 1'b0, 5'd0,  32'h0};
    vecs[13] = '{1'b1,1'b1,1'b0, 5'd9, 5'd10,5'd0, 1'b0, 3'b001, 1'b1, 1'b1, 5'd9,  32'hA000_0009};
    vecs[14] = '{1'b0,1'b1,1'b1, 5'd0, 5'd11,5'd12,1'b1, 3'b010, 1'b1, 1'b1, 5'd11, 32'hB000_000B};
    vecs[15] = '{1'b1,1'b0,1'b1, 5'd13,5'd0, 5'd14,1'b1, 3'b100, 1'b1, 1'b1, 5'd14, 32'hC000_000E};
    vecs[16] = '{1'b0,1'b0,1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 3'b000, 1'b1, 1'b0, 5'd0,  32'h0};
    vecs[17] = '{1'b0,1'b0,1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 3'b000, 1'b0, 1'b0, 5'd0,  32'h0};

    // Reset state, with a source valid to show rdy is held low.
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 5'd5, 5'd0, 5'd0, 1'b1);
    #2;
    chk("rst_ena",   {31'd0, wbck_ena},   32'd0);
    chk("rst_wdat",  wbck_wdat,           32'd0);
    chk("rst_rdidx", {27'd0, wbck_rdidx}, 32'd0);
    chk("rst_rdy",   {29'd0, md_rdy, lsu_rdy, alu_rdy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Lone ALU transfer with one-cycle latency.
    drive(1'b1, 1'b0, 1'b0, 5'd5, 5'd0, 5'd0, 1'b1);
    alu_wdat = 32'h0000_1234;
    #1;
    chk("lone_rdy", {29'd0, md_rdy, lsu_rdy, alu_rdy}, 32'd1);
    @(posedge clk); #1;
    chk("lone_ena",   {31'd0, wbck_ena},   32'd1);
    chk("lone_rdidx", {27'd0, wbck_rdidx}, 32'd5);
    chk("lone_wdat",  wbck_wdat,           32'h0000_1234);

    // Vector table, starting from a fresh reset.
    do_reset();
    for (int i = 0; i < NV; i++) begin
      if (i != 0) @(negedge clk);
      drive(vecs[i].av, vecs[i].lv, vecs[i].mv, vecs[i].ai, vecs[i].li, vecs[i].mi, vecs[i].wr);
      #1;
      chk($sformatf("v%0d_rdy", i),  {29'd0, md_rdy, lsu_rdy, alu_rdy}, {29'd0, vecs[i].e_rdy});
      chk($sformatf("v%0d_busy", i), {31'd0, wbck_busy}, {31'd0, vecs[i].e_busy});
      @(posedge clk); #1;
      chk($sformatf("v%0d_ena", i), {31'd0, wbck_ena}, {31'd0, vecs[i].e_ena});
      if (vecs[i].e_ena) begin
        chk($sformatf("v%0d_rdidx", i), {27'd0, wbck_rdidx}, {27'd0, vecs[i].e_idx});
        chk($sformatf("v%0d_wdat", i),  wbck_wdat, vecs[i].e_wdat);
      end
    end

    // Round-robin with all sources continuously valid from reset.
    begin
      logic [2:0] exp_gnt [6];
      logic [4:0] exp_idx [6];
      exp_gnt = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
      exp_idx = '{5'd1, 5'd2, 5'd3, 5'd1, 5'd2, 5'd3};
      do_reset();
      drive(1'b1, 1'b1, 1'b1, 5'd1, 5'd2, 5'd3, 1'b1);
      for (int k = 0; k < 6; k++) begin
        if (k != 0) @(negedge clk);
        #1;
        chk($sformatf("rr%0d_rdy", k), {29'd0, md_rdy, lsu_rdy, alu_rdy}, {29'd0, exp_gnt[k]});
        @(posedge clk); #1;
        chk($sformatf("rr%0d_ena", k),   {31'd0, wbck_ena},   32'd1);
        chk($sformatf("rr%0d_rdidx", k), {27'd0, wbck_rdidx}, {27'd0, exp_idx[k]});
      end
    end

    // Asynchronous reset with slot valid and sources valid: no clock edge between.
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_ena",  {31'd0, wbck_ena}, 32'd0);
    chk("arst_wdat", wbck_wdat,         32'd0);
    chk("arst_rdy",  {29'd0, md_rdy, lsu_rdy, alu_rdy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_first_rdy", {29'd0, md_rdy, lsu_rdy, alu_rdy}, 32'd1);
    @(posedge clk); #1;
    chk("arst_first_idx", {27'd0, wbck_rdidx}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
